// File: rtl/alu_input_seq.sv
// rtl/alu_input_seq.sv - Debounced button sequencer collecting ALU operands A, B and opcode.
// A synchronized, debounced confirm button steps a four-stage FSM that latches switch values.

module alu_input_seq #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    input  logic       clr,
    input  logic       rdy,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] op,
    output logic       valid,
    output logic [1:0] stage
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A   = 2'd0,
        GET_B   = 2'd1,
        GET_OP  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    logic          btn_m;
    logic          btn_s;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;
    logic          press;

    state_t        state;
    state_t        state_n;
    logic [3:0]    a_n;
    logic [3:0]    b_n;
    logic [2:0]    op_n;
    logic          valid_n;

    // Synchronizer and debouncer are deliberately untouched by clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            btn_m    <= btn;
            btn_s    <= btn_m;
            stable_d <= stable;
            if (btn_s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GET_A;
            a     <= 4'd0;
            b     <= 4'd0;
            op    <= 3'd0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            op    <= op_n;
            valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        op_n    = op;
        if (clr) begin
            state_n = GET_A;
            a_n     = 4'd0;
            b_n     = 4'd0;
            op_n    = 3'd0;
        end else begin
            case (state)
                GET_A: begin
                    if (press) begin
                        a_n     = sw;
                        state_n = GET_B;
                    end
                end
                GET_B: begin
                    if (press) begin
                        b_n     = sw;
                        state_n = GET_OP;
                    end
                end
                GET_OP: begin
                    if (press) begin
                        op_n    = sw[2:0];
                        state_n = PRESENT;
                    end
                end
                PRESENT: begin
                    // Presses here are dropped; only rdy leaves this state.
                    if (rdy) begin
                        state_n = GET_A;
                    end
                end
                default: state_n = GET_A;
            endcase
        end
        valid_n = (state_n == PRESENT);
    end

    assign stage = state;

endmodule

// File: tb/tb_alu_input_seq.sv
// tb/tb_alu_input_seq.sv - Directed self-checking bench for alu_input_seq with DB_CYCLES=4.
// Inputs change and outputs are sampled on falling clock edges unless noted.

module tb_alu_input_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn;
    logic       clr;
    logic       rdy;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       valid;
    logic [1:0] stage;

    int checks = 0;
    int errors = 0;

    alu_input_seq #(.DB_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .btn   (btn),
        .clr   (clr),
        .rdy   (rdy),
        .a     (a),
        .b     (b),
        .op    (op),
        .valid (valid),
        .stage (stage)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Debounced press lands on edge 6; the FSM reacts on edge 7.
    task automatic press_btn(input logic [3:0] v);
        sw  = v;
        btn = 1'b1;
        cycles(7);
    endtask

    task automatic release_btn();
        btn = 1'b0;
        cycles(8);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 4'h0;
        btn = 1'b0;
        clr = 1'b0;
        rdy = 1'b1;
        cycles(3);
        check("reset_stage", 8'(stage), 8'd0);
        check("reset_a", 8'(a), 8'd0);
        check("reset_valid", 8'(valid), 8'd0);
        rst = 1'b0;
        cycles(2);

        // Basic sequence with rdy tied high
        press_btn(4'h5);
        check("basic_stage1", 8'(stage), 8'd1);
        check("basic_a", 8'(a), 8'h5);
        release_btn();
        press_btn(4'h3);
        check("basic_stage2", 8'(stage), 8'd2);
        check("basic_b", 8'(b), 8'h3);
        release_btn();
        press_btn(4'h1);
        check("basic_stage3", 8'(stage), 8'd3);
        check("basic_valid_hi", 8'(valid), 8'd1);
        check("basic_op", 8'(op), 8'h1);
        cycles(1);
        check("basic_stage0", 8'(stage), 8'd0);
        check("basic_valid_lo", 8'(valid), 8'd0);
        check("basic_a_kept", 8'(a), 8'h5);
        release_btn();

        // Back-pressure
        rdy = 1'b0;
        press_btn(4'h5);
        release_btn();
        press_btn(4'h3);
        release_btn();
        press_btn(4'hE);
        check("bp_op_sw3_ignored", 8'(op), 8'h6);
        release_btn();
        cycles(20);
        check("bp_stage_hold", 8'(stage), 8'd3);
        check("bp_valid_hold", 8'(valid), 8'd1);
        press_btn(4'hF);
        release_btn();
        check("bp_a_kept", 8'(a), 8'h5);
        check("bp_b_kept", 8'(b), 8'h3);
        check("bp_op_kept", 8'(op), 8'h6);
        check("bp_stage_after_press", 8'(stage), 8'd3);
        rdy = 1'b1;
        cycles(1);
        check("bp_release_stage", 8'(stage), 8'd0);
        check("bp_release_valid", 8'(valid), 8'd0);

        // Debounce: short bounces then a held rise
        sw = 4'hA;
        for (int i = 0; i < 2; i++) begin
            btn = 1'b1;
            cycles(2);
            btn = 1'b0;
            cycles(2);
        end
        cycles(4);
        check("db_no_press_bounce", 8'(stage), 8'd0);
        btn = 1'b1;
        cycles(6);
        check("db_not_yet", 8'(stage), 8'd0);
        cycles(1);
        check("db_stage1", 8'(stage), 8'd1);
        check("db_a", 8'(a), 8'hA);
        cycles(10);
        check("db_single_press", 8'(stage), 8'd1);
        release_btn();
        check("db_no_fall_press", 8'(stage), 8'd1);

        // clr alone, then clr coinciding with a press in GET_OP
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("clr_stage", 8'(stage), 8'd0);
        check("clr_a", 8'(a), 8'd0);
        press_btn(4'h5);
        release_btn();
        press_btn(4'h3);
        release_btn();
        check("clrp_in_getop", 8'(stage), 8'd2);
        sw  = 4'h7;
        btn = 1'b1;
        cycles(6);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("clrp_stage", 8'(stage), 8'd0);
        check("clrp_abop", {a, b[3:0]}, 8'h00);
        check("clrp_op", 8'(op), 8'd0);
        check("clrp_valid", 8'(valid), 8'd0);
        cycles(3);
        check("clrp_press_dropped", 8'(stage), 8'd0);
        release_btn();

        // Asynchronous reset while in GET_B
        press_btn(4'h7);
        release_btn();
        check("ar_in_getb", 8'(stage), 8'd1);
        sw  = 4'h9;
        btn = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_stage_immediate", 8'(stage), 8'd0);
        check("ar_a_immediate", 8'(a), 8'd0);
        cycles(3);
        rst = 1'b0;
        cycles(6);
        check("ar_not_yet", 8'(stage), 8'd0);
        cycles(1);
        check("ar_stage1", 8'(stage), 8'd1);
        check("ar_a", 8'(a), 8'h9);
        cycles(10);
        check("ar_single_press", 8'(stage), 8'd1);
        release_btn();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
